// File: rtl/counter_scoreboard_if.sv
// Stimulus/result bundle for the counter reference model: the environment drives
// ENABLE/sb_D/sb_MODO and reads back the expected sb_Q/sb_RCO/sb_LOAD.
interface counter_scoreboard_if #(
    parameter int WIDTH = 4
);
    logic             ENABLE;
    logic [WIDTH-1:0] sb_D;
    logic [1:0]       sb_MODO;
    logic [WIDTH-1:0] sb_Q;
    logic             sb_RCO;
    logic             sb_LOAD;

    modport master (
        output ENABLE,
        output sb_D,
        output sb_MODO,
        input  sb_Q,
        input  sb_RCO,
        input  sb_LOAD
    );

    modport slave (
        input  ENABLE,
        input  sb_D,
        input  sb_MODO,
        output sb_Q,
        output sb_RCO,
        output sb_LOAD
    );
endinterface

// File: rtl/counter_scoreboard.sv
// Cycle-accurate golden model of the 4-bit up/down/down-by-3/load counter.
// One-edge latency, all outputs registered; no handshake and no backpressure.
module counter_scoreboard #(
    parameter int WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  RESET,
    counter_scoreboard_if.slave   bus
);
    localparam logic [1:0] MODE_UP    = 2'b00;
    localparam logic [1:0] MODE_DOWN  = 2'b01;
    localparam logic [1:0] MODE_DOWN3 = 2'b10;
    localparam logic [1:0] MODE_LOAD  = 2'b11;

    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
    localparam logic [WIDTH-1:0] THREE = WIDTH'(3);
    localparam logic [WIDTH-1:0] ZERO  = '0;
    localparam logic [WIDTH-1:0] MAXV  = '1;

    logic [WIDTH-1:0] q;
    logic             rco;
    logic             load;

    // Flags default low every edge so they can never stick; an unknown mode
    // falls through to the default arm and behaves as a hold.
    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            q    <= ZERO;
            rco  <= 1'b0;
            load <= 1'b0;
        end else begin
            rco  <= 1'b0;
            load <= 1'b0;
            if (bus.ENABLE) begin
                case (bus.sb_MODO)
                    MODE_UP: begin
                        q   <= q + ONE;
                        rco <= (q == MAXV);
                    end
                    MODE_DOWN: begin
                        q   <= q - ONE;
                        rco <= (q == ZERO);
                    end
                    MODE_DOWN3: begin
                        q   <= q - THREE;
                        rco <= (q < THREE);
                    end
                    MODE_LOAD: begin
                        q    <= bus.sb_D;
                        load <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.sb_Q    = q;
    assign bus.sb_RCO  = rco;
    assign bus.sb_LOAD = load;
endmodule

// File: tb/tb_counter_scoreboard.sv
// Directed and randomised checks of the counter reference model.
module tb_counter_scoreboard;
    logic clk;
    logic RESET;
    int   n_cmp;
    int   n_err;

    logic [3:0] exp_q;
    logic       exp_rco;
    logic       exp_load;

    counter_scoreboard_if #(.WIDTH(4)) bus ();

    counter_scoreboard #(.WIDTH(4)) dut (
        .clk   (clk),
        .RESET (RESET),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_value(input logic [3:0] v);
        bus.ENABLE  = 1'b1;
        bus.sb_MODO = 2'b11;
        bus.sb_D    = v;
        tick();
        n_cmp++;
        if (bus.sb_Q !== v || bus.sb_LOAD !== 1'b1 || bus.sb_RCO !== 1'b0) begin
            n_err++;
            $display("FAIL load_%0d: q=%0d rco=%b load=%b, required q=%0d rco=0 load=1",
                     v, bus.sb_Q, bus.sb_RCO, bus.sb_LOAD, v);
        end
    endtask

    task automatic test_reset();
        bus.ENABLE  = 1'b0;
        bus.sb_MODO = 2'b00;
        bus.sb_D    = 4'd0;
        RESET       = 1'b0;
        #2;
        n_cmp++;
        if (bus.sb_Q !== 4'd0 || bus.sb_RCO !== 1'b0 || bus.sb_LOAD !== 1'b0) begin
            n_err++;
            $display("FAIL reset_initial: q=%0d rco=%b load=%b, required 0/0/0",
                     bus.sb_Q, bus.sb_RCO, bus.sb_LOAD);
        end
        tick();
        RESET = 1'b1;
        load_value(4'd9);
        // Assert reset mid-cycle: must clear without any clock edge.
        #3;
        RESET = 1'b0;
        #1;
        n_cmp++;
        if (bus.sb_Q !== 4'd0 || bus.sb_RCO !== 1'b0 || bus.sb_LOAD !== 1'b0) begin
            n_err++;
            $display("FAIL reset_async: q=%0d rco=%b load=%b, required 0/0/0",
                     bus.sb_Q, bus.sb_RCO, bus.sb_LOAD);
        end
        bus.sb_MODO = 2'b11;
        bus.sb_D    = 4'd7;
        bus.ENABLE  = 1'b1;
        tick();
        n_cmp++;
        if (bus.sb_Q !== 4'd0 || bus.sb_LOAD !== 1'b0) begin
            n_err++;
            $display("FAIL reset_held: q=%0d load=%b, required q=0 load=0",
                     bus.sb_Q, bus.sb_LOAD);
        end
        RESET = 1'b1;
    endtask

    task automatic test_up_wrap();
        bus.ENABLE  = 1'b1;
        bus.sb_MODO = 2'b00;
        for (int i = 1; i <= 17; i++) begin
            tick();
            exp_q   = 4'(i);
            exp_rco = (i == 16);
            n_cmp++;
            if (bus.sb_Q !== exp_q || bus.sb_RCO !== exp_rco || bus.sb_LOAD !== 1'b0) begin
                n_err++;
                $display("FAIL up_step%0d: q=%0d rco=%b load=%b, required q=%0d rco=%b load=0",
                         i, bus.sb_Q, bus.sb_RCO, bus.sb_LOAD, exp_q, exp_rco);
            end
        end
    endtask

    task automatic test_down();
        logic [3:0] seq [3];
        seq = '{4'd1, 4'd0, 4'd15};
        load_value(4'd2);
        bus.sb_MODO = 2'b01;
        for (int i = 0; i < 3; i++) begin
            tick();
            exp_rco = (i == 2);
            n_cmp++;
            if (bus.sb_Q !== seq[i] || bus.sb_RCO !== exp_rco || bus.sb_LOAD !== 1'b0) begin
                n_err++;
                $display("FAIL down_step%0d: q=%0d rco=%b load=%b, required q=%0d rco=%b load=0",
                         i, bus.sb_Q, bus.sb_RCO, bus.sb_LOAD, seq[i], exp_rco);
            end
        end
    endtask

    task automatic test_down3();
        logic [3:0] seq [4];
        seq = '{4'd4, 4'd1, 4'd14, 4'd11};
        load_value(4'd7);
        bus.sb_MODO = 2'b10;
        for (int i = 0; i < 4; i++) begin
            tick();
            exp_rco = (i == 2);
            n_cmp++;
            if (bus.sb_Q !== seq[i] || bus.sb_RCO !== exp_rco || bus.sb_LOAD !== 1'b0) begin
                n_err++;
                $display("FAIL down3_step%0d: q=%0d rco=%b load=%b, required q=%0d rco=%b load=0",
                         i, bus.sb_Q, bus.sb_RCO, bus.sb_LOAD, seq[i], exp_rco);
            end
        end
    endtask

    task automatic test_hold();
        load_value(4'd5);
        bus.ENABLE = 1'b0;
        bus.sb_D   = 4'd12;
        for (int i = 0; i < 4; i++) begin
            bus.sb_MODO = 2'(i);
            tick();
            n_cmp++;
            if (bus.sb_Q !== 4'd5 || bus.sb_RCO !== 1'b0 || bus.sb_LOAD !== 1'b0) begin
                n_err++;
                $display("FAIL hold_step%0d: q=%0d rco=%b load=%b, required q=5 rco=0 load=0",
                         i, bus.sb_Q, bus.sb_RCO, bus.sb_LOAD);
            end
        end
        bus.ENABLE  = 1'b1;
        bus.sb_MODO = 2'b00;
        tick();
        n_cmp++;
        if (bus.sb_Q !== 4'd6 || bus.sb_RCO !== 1'b0 || bus.sb_LOAD !== 1'b0) begin
            n_err++;
            $display("FAIL hold_resume: q=%0d rco=%b load=%b, required q=6 rco=0 load=0",
                     bus.sb_Q, bus.sb_RCO, bus.sb_LOAD);
        end
    endtask

    task automatic test_back_to_back();
        // Mode changes every edge; counting continues from the current value.
        logic [1:0] modes [5];
        logic [3:0] ds    [5];
        logic [3:0] qs    [5];
        logic       rcos  [5];
        logic       loads [5];
        modes = '{2'b11, 2'b00, 2'b10, 2'b01, 2'b11};
        ds    = '{4'd15, 4'd3,  4'd3,  4'd3,  4'd0};
        qs    = '{4'd15, 4'd0,  4'd13, 4'd12, 4'd0};
        rcos  = '{1'b0,  1'b1,  1'b1,  1'b0,  1'b0};
        loads = '{1'b1,  1'b0,  1'b0,  1'b0,  1'b1};
        bus.ENABLE = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.sb_MODO = modes[i];
            bus.sb_D    = ds[i];
            tick();
            n_cmp++;
            if (bus.sb_Q !== qs[i] || bus.sb_RCO !== rcos[i] || bus.sb_LOAD !== loads[i]) begin
                n_err++;
                $display("FAIL b2b_step%0d: q=%0d rco=%b load=%b, required q=%0d rco=%b load=%b",
                         i, bus.sb_Q, bus.sb_RCO, bus.sb_LOAD, qs[i], rcos[i], loads[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] m_q;
        m_q = bus.sb_Q;
        for (int i = 0; i < 100; i++) begin
            bus.ENABLE  = 1'($urandom_range(0, 3) != 0);
            bus.sb_MODO = 2'($urandom_range(0, 3));
            bus.sb_D    = 4'($urandom_range(0, 15));
            exp_rco  = 1'b0;
            exp_load = 1'b0;
            exp_q    = m_q;
            if (bus.ENABLE) begin
                if (bus.sb_MODO == 2'b00) begin
                    exp_q   = 4'((m_q + 1) % 16);
                    exp_rco = (m_q == 4'd15);
                end else if (bus.sb_MODO == 2'b01) begin
                    exp_q   = 4'((m_q + 15) % 16);
                    exp_rco = (m_q == 4'd0);
                end else if (bus.sb_MODO == 2'b10) begin
                    exp_q   = 4'((m_q + 13) % 16);
                    exp_rco = (m_q <= 4'd2);
                end else begin
                    exp_q    = bus.sb_D;
                    exp_load = 1'b1;
                end
            end
            tick();
            m_q = exp_q;
            n_cmp++;
            if (bus.sb_Q !== exp_q || bus.sb_RCO !== exp_rco || bus.sb_LOAD !== exp_load) begin
                n_err++;
                $display("FAIL random_cyc%0d: q=%0d rco=%b load=%b, required q=%0d rco=%b load=%b",
                         i, bus.sb_Q, bus.sb_RCO, bus.sb_LOAD, exp_q, exp_rco, exp_load);
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_up_wrap();
        test_down();
        test_down3();
        test_hold();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
